// File: rtl/e203_dtcm_ram_arb.sv
// Two-requester round-robin arbiter in front of a single-port DTCM SRAM.
// Optional light-sleep power state machine enabled by E203_DTCM_RAM_LS_EN.
module e203_dtcm_ram_arb #(
  parameter int AW        = 14,
  parameter int DW        = 32,
  parameter int SLEEP_CYC = 16,
  localparam int MW       = DW / 8
) (
  input  logic          clk,
  input  logic          rst,

  input  logic          m0_cmd_valid,
  output logic          m0_cmd_ready,
  input  logic          m0_cmd_read,
  input  logic [AW-1:0] m0_cmd_addr,
  input  logic [DW-1:0] m0_cmd_wdata,
  input  logic [MW-1:0] m0_cmd_wmask,
  output logic          m0_rsp_valid,
  input  logic          m0_rsp_ready,
  output logic [DW-1:0] m0_rsp_rdata,

  input  logic          m1_cmd_valid,
  output logic          m1_cmd_ready,
  input  logic          m1_cmd_read,
  input  logic [AW-1:0] m1_cmd_addr,
  input  logic [DW-1:0] m1_cmd_wdata,
  input  logic [MW-1:0] m1_cmd_wmask,
  output logic          m1_rsp_valid,
  input  logic          m1_rsp_ready,
  output logic [DW-1:0] m1_rsp_rdata,

  output logic          ram_cs,
  output logic          ram_we,
  output logic [AW-1:0] ram_addr,
  output logic [MW-1:0] ram_wem,
  output logic [DW-1:0] ram_din,
  input  logic [DW-1:0] ram_dout,
  output logic          ram_ls,

  output logic          arb_idle
);

  logic          awake;
  logic          rsp_free;
  logic          gnt0;
  logic          gnt1;
  logic          gnt;
  logic          last_m1;
  logic          vld_p1;
  logic          owner_m1_p1;
  logic          read_p1;
  logic          rsp_on;
  logic [DW-1:0] rd_data;

  // Grant stage: a pending response blocks arbitration unless it is accepted this cycle
  always_comb begin
    rsp_free = !vld_p1 || (owner_m1_p1 ? m1_rsp_ready : m0_rsp_ready);
    gnt0     = 1'b0;
    gnt1     = 1'b0;
    if (!rst && awake && rsp_free) begin
      if (m0_cmd_valid && m1_cmd_valid) begin
        gnt0 = last_m1;
        gnt1 = !last_m1;
      end else begin
        gnt0 = m0_cmd_valid;
        gnt1 = m1_cmd_valid;
      end
    end
  end

  assign gnt          = gnt0 | gnt1;
  assign m0_cmd_ready = gnt0;
  assign m1_cmd_ready = gnt1;

  always_comb begin
    ram_cs   = gnt;
    ram_we   = 1'b0;
    ram_wem  = '0;
    ram_addr = m0_cmd_addr;
    ram_din  = m0_cmd_wdata;
    if (gnt1) begin
      ram_addr = m1_cmd_addr;
      ram_din  = m1_cmd_wdata;
      ram_we   = ~m1_cmd_read;
      ram_wem  = m1_cmd_read ? '0 : m1_cmd_wmask;
    end else if (gnt0) begin
      ram_we   = ~m0_cmd_read;
      ram_wem  = m0_cmd_read ? '0 : m0_cmd_wmask;
    end
  end

  // Response stage: one cycle after grant, held until the owner accepts it
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1  <= 1'b0;
      last_m1 <= 1'b1;
    end else begin
      if (gnt) begin
        vld_p1  <= 1'b1;
        last_m1 <= gnt1;
      end else if (rsp_free) begin
        vld_p1  <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (gnt) begin
      owner_m1_p1 <= gnt1;
      read_p1     <= gnt1 ? m1_cmd_read : m0_cmd_read;
    end
  end

  // The SRAM holds ram_dout while cs is low, so read data is forwarded directly
  assign rsp_on       = vld_p1 && !rst;
  assign rd_data      = read_p1 ? ram_dout : '0;
  assign m0_rsp_valid = rsp_on && !owner_m1_p1;
  assign m1_rsp_valid = rsp_on && owner_m1_p1;
  assign m0_rsp_rdata = m0_rsp_valid ? rd_data : '0;
  assign m1_rsp_rdata = m1_rsp_valid ? rd_data : '0;
  assign arb_idle     = !gnt && !rsp_on;

`ifdef E203_DTCM_RAM_LS_EN
  typedef enum logic [1:0] {AWAKE, SLEEP, WAKE} pwr_t;

  pwr_t       state;
  pwr_t       state_nxt;
  logic [7:0] idle_cnt;
  logic [7:0] idle_cnt_nxt;
  logic       any_valid;

  assign any_valid = m0_cmd_valid | m1_cmd_valid;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= AWAKE;
      idle_cnt <= 8'd0;
    end else begin
      state    <= state_nxt;
      idle_cnt <= idle_cnt_nxt;
    end
  end

  // Sleep is entered on the cycle the counter would reach SLEEP_CYC; it saturates there
  always_comb begin
    state_nxt    = state;
    idle_cnt_nxt = idle_cnt;
    case (state)
      AWAKE: begin
        if (any_valid || gnt) begin
          idle_cnt_nxt = 8'd0;
        end else if (arb_idle) begin
          if (idle_cnt >= 8'(SLEEP_CYC - 1)) begin
            idle_cnt_nxt = 8'(SLEEP_CYC);
            state_nxt    = SLEEP;
          end else begin
            idle_cnt_nxt = idle_cnt + 8'd1;
          end
        end
      end
      SLEEP: begin
        if (any_valid) state_nxt = WAKE;
      end
      WAKE: begin
        state_nxt    = AWAKE;
        idle_cnt_nxt = 8'd0;
      end
      default: begin
        state_nxt    = AWAKE;
        idle_cnt_nxt = 8'd0;
      end
    endcase
  end

  assign awake  = (state == AWAKE);
  assign ram_ls = (state == SLEEP) && !rst;
`else
  assign awake  = 1'b1;
  assign ram_ls = 1'b0;
`endif

endmodule

// File: tb/tb_e203_dtcm_ram_arb.sv
// Bench for e203_dtcm_ram_arb: vector table plus hand sequences, response scoreboard.
// Follows E203_DTCM_RAM_LS_EN to pick the sleep or no-sleep corner case.
module tb_e203_dtcm_ram_arb;

  localparam int AW = 14;
  localparam int DW = 32;
  localparam int MW = DW / 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          m0_cmd_valid = 1'b0, m0_cmd_ready, m0_cmd_read = 1'b1;
  logic [AW-1:0] m0_cmd_addr = '0;
  logic [DW-1:0] m0_cmd_wdata = '0;
  logic [MW-1:0] m0_cmd_wmask = '0;
  logic          m0_rsp_valid, m0_rsp_ready = 1'b1;
  logic [DW-1:0] m0_rsp_rdata;
  logic          m1_cmd_valid = 1'b0, m1_cmd_ready, m1_cmd_read = 1'b1;
  logic [AW-1:0] m1_cmd_addr = '0;
  logic [DW-1:0] m1_cmd_wdata = '0;
  logic [MW-1:0] m1_cmd_wmask = '0;
  logic          m1_rsp_valid, m1_rsp_ready = 1'b1;
  logic [DW-1:0] m1_rsp_rdata;
  logic          ram_cs, ram_we, ram_ls, arb_idle;
  logic [AW-1:0] ram_addr;
  logic [MW-1:0] ram_wem;
  logic [DW-1:0] ram_din;
  logic [DW-1:0] ram_dout = '0;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic          v0, rd0;
    logic [AW-1:0] a0;
    logic [MW-1:0] k0;
    logic          v1, rd1;
    logic [AW-1:0] a1;
    logic [MW-1:0] k1;
    logic          rr0, rr1;
    int            g;      // expected grant: 0 none, 1 m0, 2 m1
  } vec_t;

  typedef struct {
    logic          m1;
    logic [DW-1:0] data;
  } rsp_t;

  rsp_t exp_q[$];

  e203_dtcm_ram_arb #(.AW(AW), .DW(DW), .SLEEP_CYC(4)) dut (
    .clk(clk), .rst(rst),
    .m0_cmd_valid(m0_cmd_valid), .m0_cmd_ready(m0_cmd_ready), .m0_cmd_read(m0_cmd_read),
    .m0_cmd_addr(m0_cmd_addr), .m0_cmd_wdata(m0_cmd_wdata), .m0_cmd_wmask(m0_cmd_wmask),
    .m0_rsp_valid(m0_rsp_valid), .m0_rsp_ready(m0_rsp_ready), .m0_rsp_rdata(m0_rsp_rdata),
    .m1_cmd_valid(m1_cmd_valid), .m1_cmd_ready(m1_cmd_ready), .m1_cmd_read(m1_cmd_read),
    .m1_cmd_addr(m1_cmd_addr), .m1_cmd_wdata(m1_cmd_wdata), .m1_cmd_wmask(m1_cmd_wmask),
    .m1_rsp_valid(m1_rsp_valid), .m1_rsp_ready(m1_rsp_ready), .m1_rsp_rdata(m1_rsp_rdata),
    .ram_cs(ram_cs), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wem(ram_wem),
    .ram_din(ram_din), .ram_dout(ram_dout), .ram_ls(ram_ls), .arb_idle(arb_idle)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] mem_val(input logic [AW-1:0] a);
    return {2'b11, a, 2'b10, ~a};
  endfunction

  function automatic logic [DW-1:0] wd(input logic [AW-1:0] a);
    return {2'b01, a, 2'b11, a};
  endfunction

  // SRAM model: read data appears after the read edge and holds otherwise
  always @(posedge clk) begin
    if (ram_cs && !ram_we) ram_dout <= mem_val(ram_addr);
  end

  function automatic vec_t mk(input int v0, input int rd0, input int a0, input int k0,
                              input int v1, input int rd1, input int a1, input int k1,
                              input int rr0, input int rr1, input int g);
    vec_t v;
    v.v0 = 1'(v0);  v.rd0 = 1'(rd0); v.a0 = AW'(a0); v.k0 = MW'(k0);
    v.v1 = 1'(v1);  v.rd1 = 1'(rd1); v.a1 = AW'(a1); v.k1 = MW'(k1);
    v.rr0 = 1'(rr0); v.rr1 = 1'(rr1); v.g = g;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic set_in(input vec_t v);
    m0_cmd_valid = v.v0; m0_cmd_read = v.rd0; m0_cmd_addr = v.a0;
    m0_cmd_wmask = v.k0; m0_cmd_wdata = wd(v.a0);
    m1_cmd_valid = v.v1; m1_cmd_read = v.rd1; m1_cmd_addr = v.a1;
    m1_cmd_wmask = v.k1; m1_cmd_wdata = wd(v.a1);
    m0_rsp_ready = v.rr0; m1_rsp_ready = v.rr1;
  endtask

  task automatic drive(input vec_t v);
    @(negedge clk);
    set_in(v);
    #1;
  endtask

  task automatic check_cycle(input vec_t v);
    rsp_t e;
    logic rd;
    logic [AW-1:0] a;
    logic [MW-1:0] k;
    int pend;
    chk("m0_cmd_ready", 32'(m0_cmd_ready), 32'(v.g == 1));
    chk("m1_cmd_ready", 32'(m1_cmd_ready), 32'(v.g == 2));
    chk("ram_cs", 32'(ram_cs), 32'(v.g != 0));
    rd = (v.g == 2) ? v.rd1 : v.rd0;
    a  = (v.g == 2) ? v.a1 : v.a0;
    k  = (v.g == 2) ? v.k1 : v.k0;
    if (v.g != 0) begin
      chk("ram_we", 32'(ram_we), 32'(!rd));
      chk("ram_addr", 32'(ram_addr), 32'(a));
      chk("ram_wem", 32'(ram_wem), rd ? 32'd0 : 32'(k));
      if (!rd) chk("ram_din", ram_din, wd(a));
    end
    pend = exp_q.size();
    if (pend > 0) begin
      e = exp_q[0];
      chk("m0_rsp_valid", 32'(m0_rsp_valid), 32'(!e.m1));
      chk("m1_rsp_valid", 32'(m1_rsp_valid), 32'(e.m1));
      chk("rsp_rdata", e.m1 ? m1_rsp_rdata : m0_rsp_rdata, e.data);
      if (e.m1 ? m1_rsp_ready : m0_rsp_ready) void'(exp_q.pop_front());
    end else begin
      chk("m0_rsp_valid_idle", 32'(m0_rsp_valid), 32'd0);
      chk("m1_rsp_valid_idle", 32'(m1_rsp_valid), 32'd0);
    end
    chk("arb_idle", 32'(arb_idle), 32'(v.g == 0 && pend == 0));
    if (v.g != 0) begin
      e.m1   = (v.g == 2);
      e.data = rd ? mem_val(a) : '0;
      exp_q.push_back(e);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_m0_cmd_ready"}, 32'(m0_cmd_ready), 32'd0);
    chk({tag, "_m1_cmd_ready"}, 32'(m1_cmd_ready), 32'd0);
    chk({tag, "_m0_rsp_valid"}, 32'(m0_rsp_valid), 32'd0);
    chk({tag, "_m1_rsp_valid"}, 32'(m1_rsp_valid), 32'd0);
    chk({tag, "_m0_rsp_rdata"}, m0_rsp_rdata, 32'd0);
    chk({tag, "_m1_rsp_rdata"}, m1_rsp_rdata, 32'd0);
    chk({tag, "_ram_cs"}, 32'(ram_cs), 32'd0);
    chk({tag, "_ram_we"}, 32'(ram_we), 32'd0);
    chk({tag, "_ram_wem"}, 32'(ram_wem), 32'd0);
    chk({tag, "_ram_ls"}, 32'(ram_ls), 32'd0);
    chk({tag, "_arb_idle"}, 32'(arb_idle), 32'd1);
  endtask

  vec_t tbl[23];
  vec_t idle;
  vec_t both;
  vec_t rd0v;

  initial begin
    //             v0 rd0 a0    k0   v1 rd1 a1    k1   rr0 rr1 g
    tbl[0]  = mk(0, 1, 'h00, 0,   0, 1, 'h00, 0,   1, 1, 0);
    tbl[1]  = mk(1, 1, 'h10, 0,   0, 1, 'h00, 0,   1, 1, 1);
    tbl[2]  = mk(0, 1, 'h00, 0,   0, 1, 'h00, 0,   1, 1, 0);
    tbl[3]  = mk(1, 1, 'h20, 0,   1, 1, 'h30, 0,   1, 1, 2);
    tbl[4]  = mk(1, 1, 'h21, 0,   1, 1, 'h31, 0,   1, 1, 1);
    tbl[5]  = mk(1, 1, 'h22, 0,   1, 1, 'h32, 0,   1, 1, 2);
    tbl[6]  = mk(1, 1, 'h23, 0,   1, 1, 'h33, 0,   1, 1, 1);
    tbl[7]  = mk(0, 1, 'h00, 0,   0, 1, 'h00, 0,   1, 1, 0);
    tbl[8]  = mk(0, 1, 'h00, 0,   1, 0, 'h44, 3,   1, 0, 2);
    tbl[9]  = mk(1, 1, 'h50, 0,   0, 1, 'h00, 0,   1, 0, 0);
    tbl[10] = mk(1, 1, 'h50, 0,   0, 1, 'h00, 0,   1, 0, 0);
    tbl[11] = mk(1, 1, 'h50, 0,   0, 1, 'h00, 0,   1, 0, 0);
    tbl[12] = mk(1, 1, 'h50, 0,   0, 1, 'h00, 0,   1, 1, 1);
    tbl[13] = mk(0, 1, 'h00, 0,   0, 1, 'h00, 0,   1, 1, 0);
    tbl[14] = mk(1, 1, 'h60, 0,   1, 1, 'h70, 0,   1, 1, 2);
    tbl[15] = mk(1, 0, 'h61, 'hC, 0, 1, 'h00, 0,   1, 1, 1);
    tbl[16] = mk(0, 1, 'h00, 0,   1, 0, 'h71, 'hF, 1, 1, 2);
    tbl[17] = mk(0, 1, 'h00, 0,   0, 1, 'h00, 0,   1, 1, 0);
    tbl[18] = mk(1, 1, 'h80, 0,   0, 1, 'h00, 0,   0, 1, 1);
    tbl[19] = mk(0, 1, 'h00, 0,   1, 1, 'h90, 0,   0, 1, 0);
    tbl[20] = mk(0, 1, 'h00, 0,   0, 1, 'h00, 0,   0, 1, 0);
    tbl[21] = mk(0, 1, 'h00, 0,   0, 1, 'h00, 0,   1, 1, 0);
    tbl[22] = mk(0, 1, 'h00, 0,   0, 1, 'h00, 0,   1, 1, 0);
    idle = mk(0, 1, 0, 0, 0, 1, 0, 0, 1, 1, 0);
    both = mk(1, 1, 'h66, 0, 1, 1, 'h77, 0, 1, 1, 1);
    rd0v = mk(1, 1, 'h12, 0, 0, 1, 0, 0, 1, 1, 1);

    // Reset with both requesters asking
    @(negedge clk);
    rst = 1'b1;
    set_in(mk(1, 1, 'h5, 0, 1, 1, 'h6, 0, 1, 1, 0));
    #1;
    check_reset_outputs("reset");
    drive(idle);
    rst = 1'b0;
    drive(idle);
    exp_q.delete();

    foreach (tbl[i]) begin
      drive(tbl[i]);
      check_cycle(tbl[i]);
    end

    // Reset the cycle after a read grant: response dropped, m0 priority back
    drive(mk(1, 1, 'h55, 0, 0, 1, 0, 0, 1, 1, 1));
    check_cycle(mk(1, 1, 'h55, 0, 0, 1, 0, 0, 1, 1, 1));
    @(negedge clk);
    rst = 1'b1;
    set_in(mk(1, 1, 'h66, 0, 1, 1, 'h77, 0, 1, 1, 0));
    #1;
    check_reset_outputs("midrst");
    exp_q.delete();
    @(negedge clk);
    rst = 1'b0;
    set_in(both);
    #1;
    check_cycle(both);
    drive(idle);
    check_cycle(idle);

`ifdef E203_DTCM_RAM_LS_EN
    // Four idle cycles put the SRAM to sleep; a request costs one wake cycle
    @(negedge clk);
    rst = 1'b1;
    set_in(idle);
    #1;
    chk("ls_in_reset", 32'(ram_ls), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    exp_q.delete();
    for (int i = 0; i < 3; i++) begin
      drive(idle);
      check_cycle(idle);
      chk("ls_counting", 32'(ram_ls), 32'd0);
    end
    drive(idle);
    check_cycle(idle);
    chk("ls_asleep", 32'(ram_ls), 32'd1);
    drive(rd0v);
    check_cycle(mk(1, 1, 'h12, 0, 0, 1, 0, 0, 1, 1, 0));
    chk("ls_sleep_req", 32'(ram_ls), 32'd1);
    drive(rd0v);
    check_cycle(mk(1, 1, 'h12, 0, 0, 1, 0, 0, 1, 1, 0));
    chk("ls_wake", 32'(ram_ls), 32'd0);
    drive(rd0v);
    check_cycle(rd0v);
    chk("ls_awake_grant", 32'(ram_ls), 32'd0);
    drive(idle);
    check_cycle(idle);
`else
    // Long idle stretch never sleeps; the next request is granted at once
    for (int i = 0; i < 100; i++) begin
      drive(idle);
      chk("ls_stays_low", 32'(ram_ls), 32'd0);
    end
    drive(rd0v);
    check_cycle(rd0v);
    drive(idle);
    check_cycle(idle);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
